// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// rounded oversample divider used by the RX and TX front ends.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  // Round-to-nearest of clk_hz / (baud * osr).
  function automatic int uart_div(input longint clk_hz, input longint baud, input longint osr);
    longint den;
    den = baud * osr;
    return int'((clk_hz + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample strobe generator: one-cycle os_tick every DIV clocks, registered.
// A restart pulse zeroes the phase so the next tick lands DIV+1 clocks later.
module uart_os_tick #(
  parameter int DIV = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic os_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt     <= '0;
      os_tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt     <= '0;
      os_tick <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      os_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Self-timed UART receiver with 3-sample majority vote and a one-entry valid/ready slot.
// Word appears 1 clk after the last stop decision; a full, unconsumed slot drops the new word.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_frame: oversample divider rounds below 1");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_osr
    $error("uart_rx_frame: OVERSAMPLE must be even and at least 8");
  end

  logic                 rx_s1, rx_s2, rx_hist;
  logic                 fall, restart, os_tick, decide, vote;
  logic                 v0, v1;
  logic [SCW-1:0]       scnt;
  logic [BCW-1:0]       bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pe_acc, fe_acc, all_zero;
  rx_state_t            state;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_hist <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_hist <= rx_s2;
    end
  end

  assign fall    = rx_hist & ~rx_s2;
  assign restart = (state == ST_IDLE) && fall;
  assign decide  = os_tick && (scnt == SCW'(MID + 1));
  assign vote    = (v0 & v1) | (v0 & rx_s2) | (v1 & rx_s2);

  uart_os_tick #(.DIV(DIV)) u_os_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .os_tick (os_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      scnt          <= '0;
      bcnt          <= '0;
      v0            <= 1'b1;
      v1            <= 1'b1;
      shreg         <= '0;
      pe_acc        <= 1'b0;
      fe_acc        <= 1'b0;
      all_zero      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      break_det     <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (os_tick) begin
        scnt <= (scnt == SCW'(OVERSAMPLE - 1)) ? '0 : scnt + 1'b1;
        if (scnt == SCW'(MID - 1)) v0 <= rx_s2;
        if (scnt == SCW'(MID))     v1 <= rx_s2;
      end

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            busy     <= 1'b1;
            scnt     <= '0;
            bcnt     <= '0;
            pe_acc   <= 1'b0;
            fe_acc   <= 1'b0;
            all_zero <= 1'b1;
          end
        end
        ST_START: begin
          if (decide) begin
            if (vote) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (decide) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (vote) all_zero <= 1'b0;
            if (bcnt == BCW'(DATA_BITS - 1)) begin
              bcnt  <= '0;
              state <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (decide) begin
            pe_acc <= (^shreg) ^ vote ^ (PARITY_MODE == PARITY_ODD);
            if (vote) all_zero <= 1'b0;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide) begin
            if (!vote) fe_acc <= 1'b1;
            if (vote) all_zero <= 1'b0;
            if (bcnt == BCW'(STOP_BITS - 1)) begin
              // Commit: a full slot that is not being drained keeps its word.
              if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_valid      <= 1'b1;
                rx_data       <= shreg;
                parity_error  <= pe_acc;
                framing_error <= fe_acc | ~vote;
              end
              break_det <= all_zero & ~vote;
              bcnt      <= '0;
              state     <= vote ? ST_IDLE : ST_WAIT_HIGH;
              busy      <= ~vote;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s2) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 and a 7E2 instance driven with directed and random frames,
// checked against a frame-level model (expected-word queues plus break/overrun counts).
module tb_uart_rx_frame;

  localparam int CLK_HZ = 7_372_800;
  localparam int BAUD   = 115_200;
  localparam int BIT    = CLK_HZ / BAUD;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8, rx7;
  logic       rdy_cmd, rnd_mode, rnd_r8, rnd_r7;
  logic       rdy8, rdy7;
  logic [7:0] d8;
  logic [6:0] d7;
  logic       v8, pe8, fe8, ov8, brk8, busy8;
  logic       v7, pe7, fe7, ov7, brk7, busy7;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   nword8 = 0;
  int   nword7 = 0;
  int   nbrk [2] = '{0, 0};
  int   novr [2] = '{0, 0};
  int   exp_brk [2] = '{0, 0};
  exp_t q8[$];
  exp_t q7[$];
  exp_t m8, m7;

  always #5 clk = ~clk;

  assign rdy8 = rnd_mode ? rnd_r8 : rdy_cmd;
  assign rdy7 = rnd_mode ? rnd_r7 : 1'b1;

  uart_rx_frame #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
  ) dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
    .parity_error(pe8), .framing_error(fe8), .overrun(ov8), .break_det(brk8), .busy(busy8)
  );

  uart_rx_frame #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)
  ) dut7 (
    .clk(clk), .rst(rst), .rx(rx7), .rx_data(d7), .rx_valid(v7), .rx_ready(rdy7),
    .parity_error(pe7), .framing_error(fe7), .overrun(ov7), .break_det(brk7), .busy(busy7)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx8 = v;
    else          rx7 = v;
  endtask

  task automatic bit_out(input int sel, input logic v);
    set_line(sel, v);
    repeat (BIT) tick();
  endtask

  // One frame on line sel (0 = 8N1, 1 = 7E2). keep=0 means the word is expected to be dropped.
  task automatic send(input int sel, input logic [8:0] d, input bit flip, input bit stop_low, input bit keep);
    int         nb, ns;
    bit         par_on, pbit;
    logic [8:0] dm;
    exp_t       e;
    nb     = (sel == 0) ? 8 : 7;
    ns     = (sel == 0) ? 1 : 2;
    par_on = (sel != 0);
    dm     = d & ((9'd1 << nb) - 9'd1);
    pbit   = (($countones(dm) % 2) == 1) ^ flip;
    e.d    = dm;
    e.pe   = par_on && ((($countones(dm) + int'(pbit)) % 2) != 0);
    e.fe   = stop_low;
    if (keep) begin
      if (sel == 0) q8.push_back(e);
      else          q7.push_back(e);
    end
    if (stop_low && dm == 9'd0 && (!par_on || !pbit)) exp_brk[sel]++;
    bit_out(sel, 1'b0);
    for (int i = 0; i < nb; i++) bit_out(sel, dm[i]);
    if (par_on) bit_out(sel, pbit);
    for (int i = 0; i < ns; i++) bit_out(sel, !stop_low);
    bit_out(sel, 1'b1);
    bit_out(sel, 1'b1);
  endtask

  always @(posedge clk) begin
    #1;
    rnd_r8 = ($urandom_range(0, 3) != 0);
    rnd_r7 = ($urandom_range(0, 3) != 0);
  end

  // Consumer side: every handshake must match the head of the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (v8 && rdy8) begin
        nword8++;
        if (q8.size() == 0) m8 = '{d: 9'h1FF, pe: 1'b0, fe: 1'b0};
        else                m8 = q8.pop_front();
        chk("data8", {24'd0, d8}, {23'd0, m8.d});
        chk("perr8", {31'd0, pe8}, {31'd0, m8.pe});
        chk("ferr8", {31'd0, fe8}, {31'd0, m8.fe});
      end
      if (v7 && rdy7) begin
        nword7++;
        if (q7.size() == 0) m7 = '{d: 9'h1FF, pe: 1'b0, fe: 1'b0};
        else                m7 = q7.pop_front();
        chk("data7", {25'd0, d7}, {23'd0, m7.d});
        chk("perr7", {31'd0, pe7}, {31'd0, m7.pe});
        chk("ferr7", {31'd0, fe7}, {31'd0, m7.fe});
      end
      if (brk8) nbrk[0]++;
      if (brk7) nbrk[1]++;
      if (ov8)  novr[0]++;
      if (ov7)  novr[1]++;
    end
  end

  initial begin
    int         w;
    bit         seen;
    logic [7:0] pd;
    logic [8:0] rd;
    rx8 = 1'b1; rx7 = 1'b1; rdy_cmd = 1'b1; rnd_mode = 1'b0; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_valid8", {31'd0, v8}, 32'd0);
    chk("rst_data8", {24'd0, d8}, 32'd0);
    chk("rst_flags8", {28'd0, pe8, fe8, ov8, brk8}, 32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_valid7", {31'd0, v7}, 32'd0);
    chk("rst_data7", {25'd0, d7}, 32'd0);

    // 8N1 clean words
    send(0, 9'h0A5, 1'b0, 1'b0, 1'b1);
    send(0, 9'h03C, 1'b0, 1'b0, 1'b1);
    repeat (BIT) tick();
    chk("8n1_drain", q8.size(), 32'd0);
    chk("8n1_words", nword8, 32'd2);

    // 7E2: correct parity, then flipped parity
    send(1, 9'h041, 1'b0, 1'b0, 1'b1);
    send(1, 9'h041, 1'b1, 1'b0, 1'b1);
    repeat (BIT) tick();
    chk("7e2_drain", q7.size(), 32'd0);
    chk("7e2_words", nword7, 32'd2);

    // Glitch on an idle line
    w = nword8;
    rx8 = 1'b0;
    repeat (3) tick();
    rx8 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy8) seen = 1'b1;
    end
    chk("glitch_busy_seen", {31'd0, seen}, 32'd1);
    repeat (2 * BIT) tick();
    chk("glitch_idle", {31'd0, busy8}, 32'd0);
    chk("glitch_words", nword8, w);

    // Overrun: slot stays full with the first word, second is dropped
    rdy_cmd = 1'b0;
    send(0, 9'h011, 1'b0, 1'b0, 1'b1);
    send(0, 9'h022, 1'b0, 1'b0, 1'b0);
    chk("ovr_hold_data", {24'd0, d8}, 32'h11);
    chk("ovr_hold_valid", {31'd0, v8}, 32'd1);
    chk("ovr_pulses", novr[0], 32'd1);
    rdy_cmd = 1'b1;
    repeat (10) tick();
    chk("ovr_drain", q8.size(), 32'd0);
    chk("ovr_slot_empty", {31'd0, v8}, 32'd0);

    // Break: a frame of all-zero votes yields one word 0x00 with framing error, then silence
    w = nword8;
    q8.push_back('{d: 9'h000, pe: 1'b0, fe: 1'b1});
    exp_brk[0]++;
    rx8 = 1'b0;
    repeat (20 * BIT) tick();
    chk("brk_busy_held", {31'd0, busy8}, 32'd1);
    chk("brk_one_word", nword8 - w, 32'd1);
    rx8 = 1'b1;
    repeat (2 * BIT) tick();
    send(0, 9'h055, 1'b0, 1'b0, 1'b1);
    repeat (BIT) tick();
    chk("brk_pulses", nbrk[0], exp_brk[0]);
    chk("brk_drain", q8.size(), 32'd0);

    // Reset during data bit 4 (a high bit, so the line stays idle afterwards)
    w = nword8;
    pd = 8'hB6;
    bit_out(0, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(0, pd[i]);
    rx8 = pd[4];
    repeat (BIT / 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy8}, 32'd0);
    chk("rst_mid_valid", {31'd0, v8}, 32'd0);
    rx8 = 1'b1;
    repeat (12 * BIT) tick();
    chk("rst_mid_words", nword8, w);
    send(0, 9'h00F, 1'b0, 1'b0, 1'b1);
    repeat (BIT) tick();
    chk("rst_mid_drain", q8.size(), 32'd0);

    // Random frames with a randomly stalling consumer
    rnd_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom);
      send(0, rd, 1'b0, ($urandom_range(0, 5) == 0), 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      rd = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom);
      send(1, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'b1);
    end
    rnd_mode = 1'b0;
    repeat (2 * BIT) tick();
    chk("rand_drain8", q8.size(), 32'd0);
    chk("rand_drain7", q7.size(), 32'd0);
    chk("rand_brk8", nbrk[0], exp_brk[0]);
    chk("rand_brk7", nbrk[1], exp_brk[1]);
    chk("rand_ovr8", novr[0], 32'd1);
    chk("rand_ovr7", novr[1], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
